// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback scheduler slice.
package regfile_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;

   typedef logic [AW-1:0] reg_addr_t;

   typedef struct packed {
      logic            valid;
      reg_addr_t       rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

   typedef enum logic {
      LAST_A = 1'b0,
      LAST_B = 1'b1
   } rr_last_t;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way writeback arbiter: round-robin (RR_EN=1) or fixed A-over-B priority.
module wb_rr_arb2
   import regfile_pkg::*;
#(
   parameter int unsigned RR_EN = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   rr_last_t last_q, last_d;

   // bit 0 = source A, bit 1 = source B; pointer moves only on a grant
   always_comb begin
      gnt    = '0;
      last_d = last_q;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ((RR_EN == 0) || (last_q == LAST_B)) ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
      if (gnt[0]) begin
         last_d = LAST_A;
      end else if (gnt[1]) begin
         last_d = LAST_B;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= LAST_B;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and busy-bit scoreboard in front of the register file's
// single write port; registered output stage drives the write port directly.
module regfile_wb_sched
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN  = regfile_pkg::XLEN,
   parameter int unsigned NREG  = regfile_pkg::NREG,
   parameter int unsigned AW    = regfile_pkg::AW,
   parameter int unsigned RR_EN = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [AW-1:0]   a_rd,
   input  logic [XLEN-1:0] a_data,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic [AW-1:0]   b_rd,
   input  logic [XLEN-1:0] b_data,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ready,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic            hazard,
   output logic            wer,
   output logic [AW-1:0]   rd,
   output logic [XLEN-1:0] regdata,
   output logic [NREG-1:0] busy_vec
);

   logic [1:0]      gnt;
   wb_req_t         req_a, req_b, win;
   logic            xfer;

   logic            wer_q, wer_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [NREG-1:0] busy_q, busy_d;

   wb_rr_arb2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({b_valid, a_valid}),
      .gnt   (gnt)
   );

   always_comb begin
      req_a   = '{valid: a_valid, rd: a_rd, data: a_data};
      req_b   = '{valid: b_valid, rd: b_rd, data: b_data};
      win     = gnt[1] ? req_b : req_a;
      xfer    = (|gnt) && win.valid;
      a_ready = gnt[0];
      b_ready = gnt[1];
   end

   // x0 transfers complete the handshake but never raise the write enable
   always_comb begin
      wer_d  = xfer && (win.rd != '0);
      rd_d   = xfer ? win.rd   : rd_q;
      data_d = xfer ? win.data : data_q;
   end

   always_comb begin
      issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
      hazard      = ((rs1 != '0) && busy_q[rs1]) || ((rs2 != '0) && busy_q[rs2]);
   end

   // clear on the commit edge first so a same-edge issue of that register wins
   always_comb begin
      busy_d = busy_q;
      if (wer_q) begin
         busy_d[rd_q] = 1'b0;
      end
      if (issue_valid && issue_ready && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wer_q  <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         wer_q  <= wer_d;
         rd_q   <= rd_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      wer      = wer_q;
      rd       = rd_q;
      regdata  = data_q;
      busy_vec = busy_q;
   end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench: directed vector table, hand-written reset sequences and
// randomized traffic against a behavioural model, for both arbitration modes.
module tb_regfile_wb_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, b_valid, issue_valid;
   logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2;
   logic [31:0] a_data, b_data;

   logic        rr_a_ready, rr_b_ready, rr_issue_ready, rr_hazard, rr_wer;
   logic [4:0]  rr_rd;
   logic [31:0] rr_regdata, rr_busy_vec;
   logic        fx_a_ready, fx_b_ready, fx_issue_ready, fx_hazard, fx_wer;
   logic [4:0]  fx_rd;
   logic [31:0] fx_regdata, fx_busy_vec;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regfile_wb_sched #(.XLEN(32), .NREG(32), .AW(5), .RR_EN(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(rr_a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(rr_b_ready), .b_rd(b_rd), .b_data(b_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(rr_issue_ready),
      .rs1(rs1), .rs2(rs2), .hazard(rr_hazard),
      .wer(rr_wer), .rd(rr_rd), .regdata(rr_regdata), .busy_vec(rr_busy_vec)
   );

   regfile_wb_sched #(.XLEN(32), .NREG(32), .AW(5), .RR_EN(0)) u_fx (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(fx_a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(fx_b_ready), .b_rd(b_rd), .b_data(b_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(fx_issue_ready),
      .rs1(rs1), .rs2(rs2), .hazard(fx_hazard),
      .wer(fx_wer), .rd(fx_rd), .regdata(fx_regdata), .busy_vec(fx_busy_vec)
   );

   // Reference model, index 0 = fixed priority, 1 = round-robin
   bit [31:0]   m_busy [2];
   bit          m_wer  [2];
   logic [4:0]  m_rd   [2];
   logic [31:0] m_data [2];
   bit          m_lastb[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_busy[c]  = '0;
         m_wer[c]   = 1'b0;
         m_rd[c]    = '0;
         m_data[c]  = '0;
         m_lastb[c] = 1'b1;
      end
   endtask

   function automatic bit m_a_wins(input int c);
      return a_valid && (!b_valid || (c == 0) || m_lastb[c]);
   endfunction

   task automatic check_model();
      for (int c = 0; c < 2; c++) begin
         bit awin, bwin, ir, hz;
         logic        d_ar, d_br, d_ir, d_hz, d_wer;
         logic [4:0]  d_rd;
         logic [31:0] d_dat, d_busy;
         string       s;
         s    = (c == 1) ? "rr" : "fx";
         awin = m_a_wins(c);
         bwin = b_valid && !awin;
         ir   = (issue_rd == 0) || !m_busy[c][issue_rd];
         hz   = ((rs1 != 0) && m_busy[c][rs1]) || ((rs2 != 0) && m_busy[c][rs2]);
         if (c == 1) begin
            d_ar = rr_a_ready; d_br = rr_b_ready; d_ir = rr_issue_ready; d_hz = rr_hazard;
            d_wer = rr_wer; d_rd = rr_rd; d_dat = rr_regdata; d_busy = rr_busy_vec;
         end else begin
            d_ar = fx_a_ready; d_br = fx_b_ready; d_ir = fx_issue_ready; d_hz = fx_hazard;
            d_wer = fx_wer; d_rd = fx_rd; d_dat = fx_regdata; d_busy = fx_busy_vec;
         end
         chk({s, ".a_ready"},     32'(d_ar),  32'(awin));
         chk({s, ".b_ready"},     32'(d_br),  32'(bwin));
         chk({s, ".issue_ready"}, 32'(d_ir),  32'(ir));
         chk({s, ".hazard"},      32'(d_hz),  32'(hz));
         chk({s, ".wer"},         32'(d_wer), 32'(m_wer[c]));
         chk({s, ".busy_vec"},    d_busy,     m_busy[c]);
         if (m_wer[c]) begin
            chk({s, ".rd"},      32'(d_rd), 32'(m_rd[c]));
            chk({s, ".regdata"}, d_dat,     m_data[c]);
         end
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < 2; c++) begin
         bit          awin, bwin, ir;
         logic [4:0]  wrd;
         logic [31:0] wdat;
         awin = m_a_wins(c);
         bwin = b_valid && !awin;
         ir   = (issue_rd == 0) || !m_busy[c][issue_rd];
         wrd  = awin ? a_rd : b_rd;
         wdat = awin ? a_data : b_data;
         if (m_wer[c]) m_busy[c][m_rd[c]] = 1'b0;
         if (issue_valid && ir && issue_rd != 0) m_busy[c][issue_rd] = 1'b1;
         m_wer[c] = (awin || bwin) && (wrd != 0);
         if (awin || bwin) begin
            m_rd[c]    = wrd;
            m_data[c]  = wdat;
            m_lastb[c] = bwin;
         end
      end
   endtask

   task automatic idle_inputs();
      a_valid = 0; a_rd = 0; a_data = 0;
      b_valid = 0; b_rd = 0; b_data = 0;
      issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
   endtask

   // Called at posedge+1 with inputs applied; returns at the next posedge+1
   task automatic step();
      #3;
      check_model();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic av; logic [4:0] ard; logic [31:0] ad;
      logic bv; logic [4:0] brd; logic [31:0] bd;
      logic iv; logic [4:0] ird; logic [4:0] r1; logic [4:0] r2;
      logic ea; logic eb; logic eir; logic ehz; logic ewer;
      logic [4:0] erd; logic [31:0] edat; logic [31:0] ebusy;
   } vec_t;

   vec_t tbl[15];

   initial begin
      //          av ard ad            bv brd bd     iv ird r1 r2  ea eb ir hz wer rd dat           busy
      tbl[0]  = '{0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  0, 0,  0, 0, 1, 0, 0,  0, 32'h0,        32'h0};
      tbl[1]  = '{0, 0, 32'h0,         0, 0, 32'h0,  1, 5,  0, 0,  0, 0, 1, 0, 0,  0, 32'h0,        32'h0};
      tbl[2]  = '{0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  5, 0,  0, 0, 1, 1, 0,  0, 32'h0,        32'h20};
      tbl[3]  = '{1, 5, 32'hDEADBEEF,  0, 0, 32'h0,  0, 0,  5, 0,  1, 0, 1, 1, 0,  0, 32'h0,        32'h20};
      tbl[4]  = '{0, 0, 32'h0,         0, 0, 32'h0,  0, 5,  5, 0,  0, 0, 0, 1, 1,  5, 32'hDEADBEEF, 32'h20};
      tbl[5]  = '{0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  5, 0,  0, 0, 1, 0, 0,  0, 32'h0,        32'h0};
      tbl[6]  = '{1, 1, 32'h11,        1, 2, 32'h22, 0, 0,  0, 0,  0, 1, 1, 0, 0,  0, 32'h0,        32'h0};
      tbl[7]  = '{1, 1, 32'h11,        1, 2, 32'h22, 0, 0,  0, 0,  1, 0, 1, 0, 1,  2, 32'h22,       32'h0};
      tbl[8]  = '{1, 1, 32'h11,        1, 2, 32'h22, 0, 0,  0, 0,  0, 1, 1, 0, 1,  1, 32'h11,       32'h0};
      tbl[9]  = '{1, 1, 32'h11,        1, 2, 32'h22, 0, 0,  0, 0,  1, 0, 1, 0, 1,  2, 32'h22,       32'h0};
      tbl[10] = '{0, 0, 32'h0,         0, 0, 32'h0,  1, 7,  0, 0,  0, 0, 1, 0, 1,  1, 32'h11,       32'h0};
      tbl[11] = '{0, 0, 32'h0,         0, 0, 32'h0,  1, 7,  0, 0,  0, 0, 0, 0, 0,  0, 32'h0,        32'h80};
      tbl[12] = '{0, 0, 32'h0,         0, 0, 32'h0,  1, 0,  0, 7,  0, 0, 1, 1, 0,  0, 32'h0,        32'h80};
      tbl[13] = '{1, 0, 32'h55,        0, 0, 32'h0,  0, 0,  0, 0,  1, 0, 1, 0, 0,  0, 32'h0,        32'h80};
      tbl[14] = '{0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  0, 0,  0, 0, 1, 0, 0,  0, 32'h0,        32'h80};

      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      model_edge();
      #1;

      // Directed table against the round-robin instance
      for (int i = 0; i < 15; i++) begin
         a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].ad;
         b_valid = tbl[i].bv; b_rd = tbl[i].brd; b_data = tbl[i].bd;
         issue_valid = tbl[i].iv; issue_rd = tbl[i].ird; rs1 = tbl[i].r1; rs2 = tbl[i].r2;
         #2;
         chk($sformatf("tbl%0d.a_ready", i),     32'(rr_a_ready),     32'(tbl[i].ea));
         chk($sformatf("tbl%0d.b_ready", i),     32'(rr_b_ready),     32'(tbl[i].eb));
         chk($sformatf("tbl%0d.issue_ready", i), 32'(rr_issue_ready), 32'(tbl[i].eir));
         chk($sformatf("tbl%0d.hazard", i),      32'(rr_hazard),      32'(tbl[i].ehz));
         chk($sformatf("tbl%0d.wer", i),         32'(rr_wer),         32'(tbl[i].ewer));
         chk($sformatf("tbl%0d.busy_vec", i),    rr_busy_vec,         tbl[i].ebusy);
         if (tbl[i].ewer) begin
            chk($sformatf("tbl%0d.rd", i),      32'(rr_rd),  32'(tbl[i].erd));
            chk($sformatf("tbl%0d.regdata", i), rr_regdata,  tbl[i].edat);
         end
         #1;
         check_model();
         @(posedge clk);
         model_edge();
         #1;
      end

      // Contention straight after reset: RR grants A first, fixed keeps A until it drops
      do_reset();
      a_valid = 1; a_rd = 1; a_data = 32'h11;
      b_valid = 1; b_rd = 2; b_data = 32'h22;
      #2;
      chk("rr.first_tie_a", 32'(rr_a_ready), 32'd1);
      #1;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk($sformatf("fx.a_hold%0d", i), 32'(fx_b_ready), 32'd0);
         #1;
         check_model();
         @(posedge clk);
         model_edge();
         #1;
      end
      a_valid = 0;
      #2;
      chk("fx.b_after_a_drop", 32'(fx_b_ready), 32'd1);
      #1;
      step();
      b_valid = 0;
      step();

      // Asynchronous reset while a write is in flight and r7 is busy
      do_reset();
      issue_valid = 1; issue_rd = 7;
      step();
      issue_valid = 0; issue_rd = 0;
      a_valid = 1; a_rd = 3; a_data = 32'h33; rs1 = 7;
      step();
      a_valid = 0;
      chk("pre_rst.wer",      32'(rr_wer),    32'd1);
      chk("pre_rst.busy_vec", rr_busy_vec,    32'h80);
      chk("pre_rst.hazard",   32'(rr_hazard), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst.rr_wer",      32'(rr_wer),    32'd0);
      chk("async_rst.rr_busy_vec", rr_busy_vec,    32'h0);
      chk("async_rst.rr_hazard",   32'(rr_hazard), 32'd0);
      chk("async_rst.fx_wer",      32'(fx_wer),    32'd0);
      chk("async_rst.fx_busy_vec", fx_busy_vec,    32'h0);
      chk("async_rst.fx_hazard",   32'(fx_hazard), 32'd0);
      idle_inputs();
      #1;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      model_edge();
      #1;

      // Randomized traffic on a small register window to force conflicts
      for (int i = 0; i < 400; i++) begin
         a_valid     = 1'($urandom_range(0, 1));
         a_rd        = 5'($urandom_range(0, 7));
         a_data      = $urandom;
         b_valid     = 1'($urandom_range(0, 1));
         b_rd        = 5'($urandom_range(0, 7));
         b_data      = $urandom;
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = 5'($urandom_range(0, 7));
         rs1         = 5'($urandom_range(0, 7));
         rs2         = 5'($urandom_range(0, 7));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Writeback scheduler and scoreboard in front of the 32x32 register file's single write port.
- Arbitrates two writeback sources onto the port: A (ALU) and B (load unit). A registered output stage drives the write-enable, rd and regdata inputs directly.
- Tracks one busy bit per architectural register, covering issued-but-unwritten destinations.
- Reports RAW hazards on the two read-port addresses and blocks WAW issue.

Parameters:
- XLEN, 32, data width of writeback values.
- NREG, 32, number of architectural registers.
- AW, 5, register address width; NREG == 2**AW.
- RR_EN, 1, 1 = round-robin between A and B; 0 = fixed priority, A over B.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  source A has a writeback.
- a_ready  out  1  source A writeback accepted this cycle.
- a_rd  in  AW  source A destination register.
- a_data  in  XLEN  source A write value.
- b_valid  in  1  source B has a writeback.
- b_ready  out  1  source B writeback accepted this cycle.
- b_rd  in  AW  source B destination register.
- b_data  in  XLEN  source B write value.
- issue_valid  in  1  decode is issuing an instruction that writes issue_rd.
- issue_rd  in  AW  destination register being issued.
- issue_ready  out  1  issue permitted; no WAW conflict.
- rs1  in  AW  read-port 1 address.
- rs2  in  AW  read-port 2 address.
- hazard  out  1  a source operand is pending; decode must stall.
- wer  out  1  register file write enable (registered).
- rd  out  AW  register file write address (registered).
- regdata  out  XLEN  register file write data (registered).
- busy_vec  out  NREG  scoreboard state; bit 0 is always 0.

Behaviour:
- Reset: all outputs and state go to 0 asynchronously: wer=0, rd=0, regdata=0, busy_vec=0. The round-robin pointer resets to "last granted = B", so A wins the first tie.
- Handshake: a writeback transfers in a cycle where valid && ready.
  - Ready is combinational from both valids. The write port never back-pressures.
  - If only one source is valid, that source gets ready=1.
  - If both are valid, exactly one gets ready=1. With RR_EN=1 it is the source not granted last; with RR_EN=0 it is A.
  - Neither valid: both ready=0.
  - Sources must not derive valid from ready.
- Pointer: the round-robin pointer updates only on a granted transfer.
- Output stage, 1-cycle latency:
  - On a transfer at edge N, wer/rd/regdata carry the winner at cycle N+1.
  - The register file commits at the end of cycle N+1.
  - With no transfer, wer=0 next cycle; rd and regdata hold their previous values.
- x0 writes: a transfer with rd=0 completes the handshake, but the output stage gets wer=0.
- Scoreboard:
  - Issue: at an edge with issue_valid && issue_ready && issue_rd!=0, set busy[issue_rd].
  - Clear: at an edge where wer=1 (the register file commit edge), clear busy[rd].
  - Same register set and cleared on the same edge: set wins.
  - Writes to a non-busy register are legal and leave busy unchanged.
- issue_ready = (issue_rd==0) || !busy[issue_rd]. This is conservative: it stays 0 even in the clearing cycle.
- hazard = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]). It is combinational from registered busy, so it clears the cycle after the commit edge. The register file then holds the new value, so no bypass is needed.
- Reset mid-operation: any in-flight output-stage write is dropped (wer forced to 0) and all busy bits clear. Upstream is expected to flush.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN, AW, NREG constants;
  - the typedef reg_addr_t (logic [AW-1:0]);
  - the typedef wb_req_t (struct: valid, rd, data).
- One natural sub-module, wb_rr_arb2: a 2-way round-robin/fixed arbiter producing the grant vector and the pointer update.
- Scoreboard and output stage live in the top module.

Test Plan:
- Reset release, idle -> wer=0, busy_vec=0, hazard=0, issue_ready=1.
- Issue rd=5 -> busy_vec=0x20. Then rs1=5 -> hazard=1. A writes rd=5, data=0xDEADBEEF -> next cycle wer=1, rd=5, regdata=0xDEADBEEF. Cycle after that: busy_vec=0, hazard=0.
- A and B both valid every cycle, RR_EN=1: a_rd=1/0x11 and b_rd=2/0x22 -> grants alternate A,B,A,B starting with A; the output stage shows rd 1,2,1,2.
- Same contention with RR_EN=0 -> a_ready=1 every cycle, b_ready=0 until a_valid drops; then B goes on the next cycle.
- WAW and x0: with busy[7]=1, issue_rd=7 -> issue_ready=0. issue_rd=0 -> issue_ready=1, no busy bit set. A transfer with rd=0 -> a_ready=1 and wer=0 next cycle.
- Assert rst_n low async while wer=1 and busy_vec=0x80 -> wer, busy_vec and hazard are 0 immediately, before the next clock edge.
